// File: rtl/chan_stream_mux.sv
// chan_stream_mux: registered N-channel valid/ready stream multiplexer.
// Grant comes from sel (mode=0) or a round-robin arbiter (mode=1).
// The winning beat is loaded into a single output register.
// Optional macro CHAN_STREAM_MUX_COUNT_EN adds a 16-bit beat_count output
// that counts completed output transfers.
module chan_stream_mux #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned NCH   = 4,
    localparam int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
`ifdef CHAN_STREAM_MUX_COUNT_EN
    ,
    output logic [15:0]          beat_count
`endif
);

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  gnt;
    logic             gnt_valid;
    logic [WIDTH-1:0] gnt_data;
    logic             can_load;
    logic             xfer;

    assign can_load = ~out_valid | out_ready;
    assign xfer     = ~reset & enable & can_load & gnt_valid;

    // Grant selection: manual select, or first valid channel at/after rr_ptr.
    // Round-robin runs two descending passes so the last write is the lowest
    // valid index >= rr_ptr, falling back to the lowest valid index below it.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        if (!mode) begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (SELW'(i) == sel && in_valid[i]) begin
                    gnt       = SELW'(i);
                    gnt_valid = 1'b1;
                end
            end
        end else begin
            for (int i = int'(NCH) - 1; i >= 0; i--) begin
                if (in_valid[i] && SELW'(i) < rr_ptr) begin
                    gnt       = SELW'(i);
                    gnt_valid = 1'b1;
                end
            end
            for (int i = int'(NCH) - 1; i >= 0; i--) begin
                if (in_valid[i] && SELW'(i) >= rr_ptr) begin
                    gnt       = SELW'(i);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (SELW'(i) == gnt) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready toward the granted channel only when a transfer happens.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (xfer && SELW'(i) == gnt) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Output register, channel tag and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_chan  <= gnt;
                if (mode) begin
                    rr_ptr <= (gnt == SELW'(NCH - 1)) ? '0 : gnt + SELW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CHAN_STREAM_MUX_COUNT_EN
    // Completed output transfers, wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
        end else if (out_valid && out_ready) begin
            beat_count <= beat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_chan_stream_mux.sv
// Scoreboard bench for chan_stream_mux (NCH=4 main instance, NCH=3 instance
// for non-power-of-two wrap and out-of-range select).
module tb_chan_stream_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, mode, out_ready;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_chan;

    logic        enable3, mode3, out_ready3;
    logic [1:0]  sel3;
    logic [11:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [3:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  out_chan3;

`ifdef CHAN_STREAM_MUX_COUNT_EN
    logic [15:0] beat_count, beat_count3;
`endif

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    chan_stream_mux #(.WIDTH(4), .NCH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan)
`ifdef CHAN_STREAM_MUX_COUNT_EN
        , .beat_count(beat_count)
`endif
    );

    chan_stream_mux #(.WIDTH(4), .NCH(3)) dut3 (
        .clk(clk), .reset(reset), .enable(enable3), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_chan(out_chan3)
`ifdef CHAN_STREAM_MUX_COUNT_EN
        , .beat_count(beat_count3)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat consumed downstream is compared against the queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got chan %0d data %0h expected none", out_chan, out_data);
            end else begin
                chk("sb_beat", {26'd0, out_chan, out_data}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
        in_data = 16'h3210; in_valid = 4'b1111;
        enable3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b0;
        in_data3 = 12'h210; in_valid3 = 3'b000;
        step(); step();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        reset = 1'b0;

        // Manual select of channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 16'h3A10;
        @(negedge clk);
        chk("man_in_ready", 32'(in_ready), 32'h4);
        exp_q.push_back({2'd2, 4'hA});
        step();
        sel = 2'd3; in_valid = 4'b0000;
        @(negedge clk);
        chk("man_out_valid", 32'(out_valid), 32'd1);
        chk("man_sel3_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("man_drop_valid", 32'(out_valid), 32'd0);
        chk("man_hold_data", 32'(out_data), 32'hA);

        // Backpressure: beat 5 on channel 1 stalls for 3 cycles
        step();
        sel = 2'd1; in_valid = 4'b0010; in_data = 16'h7654; out_ready = 1'b0;
        exp_q.push_back({2'd1, 4'h5});
        step();
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'h5);
            step();
        end
        out_ready = 1'b1; sel = 2'd0;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        exp_q.push_back({2'd0, 4'h4});
        step();
        in_valid = 4'b0000;
        step();
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Round-robin with all channels valid: 0,1,2,3,0
        step();
        mode = 1'b1; in_valid = 4'b1111; in_data = 16'h3210;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            exp_q.push_back({2'(k % 4), 4'(k % 4)});
            step();
        end
        // rr_ptr=1 now; channels 3 and 0 valid
        in_valid = 4'b1001;
        @(negedge clk);
        chk("rr_skip_to3", 32'(in_ready), 32'h8);
        exp_q.push_back({2'd3, 4'h3});
        step();
        @(negedge clk);
        chk("rr_wrap_to0", 32'(in_ready), 32'h1);
        exp_q.push_back({2'd0, 4'h0});
        step();
        in_valid = 4'b0000;
        step();

        // Enable low: held beat drains, nothing new loads
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b0;
        exp_q.push_back({2'd2, 4'h2});
        step();
        enable = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
        @(negedge clk);
        chk("en0_in_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("en0_drained", 32'(out_valid), 32'd0);
        chk("en0_in_ready2", 32'(in_ready), 32'd0);
`ifdef CHAN_STREAM_MUX_COUNT_EN
        chk("beat_count", 32'(beat_count), 32'd11);
`endif

        // Reset mid-cycle discards a held beat
        step();
        enable = 1'b1; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_data", 32'(out_data), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_chan", 32'(out_chan), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
`ifdef CHAN_STREAM_MUX_COUNT_EN
        chk("rst_beat_count", 32'(beat_count), 32'd0);
`endif
        in_valid = 4'b0000;
        step();
        reset = 1'b0;
        step();

        // NCH=3 instance: round-robin wraps 2 -> 0
        enable3 = 1'b1; mode3 = 1'b1; in_valid3 = 3'b111; out_ready3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("n3_rr_ready", 32'(in_ready3), 32'(3'b001 << (k % 3)));
            step();
            chk("n3_rr_chan", 32'(out_chan3), 32'(k % 3));
            chk("n3_rr_data", 32'(out_data3), 32'(k % 3));
        end
        // Manual sel=3 is out of range and never grants
        mode3 = 1'b0; sel3 = 2'd3;
        @(negedge clk);
        chk("n3_sel3_ready", 32'(in_ready3), 32'd0);
        step();
        @(negedge clk);
        chk("n3_sel3_valid", 32'(out_valid3), 32'd0);

        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
